// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
package sdram_pkg;

    // Arbiter sequencing: grant, issue strobe, wait for busy rise, wait for busy fall.
    typedef enum logic [1:0] {IDLE, CMD, WAITH, WAITL} state_t;

    typedef enum logic {OP_RD, OP_WR} op_t;

    // Cycles the controller may take to raise busy after a strobe before it is an error.
    localparam int unsigned WaithLimit = 4;

    function automatic int unsigned addr_bits(input int unsigned bank_bits,
                                              input int unsigned row_bits,
                                              input int unsigned col_bits);
        return bank_bits + row_bits + col_bits;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at N.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx,
    output logic            any
);

    int unsigned     k;
    logic [IdxW-1:0] k_idx;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        k_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            k_idx = IdxW'(k);
            if (!any && req[k_idx]) begin
                any        = 1'b1;
                gnt[k_idx] = 1'b1;
                idx        = k_idx;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// N-client round-robin front end for the single-port SDRAM controller.
// One operation in flight at a time; read data returned on the shared p_dr bus.
// Optional build macro SDRAM_ARB_PRIO0_EN: port 0 gets fixed priority and
// round-robin covers ports 1..NPORTS-1 only.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned NPORTS   = 4,
    parameter int unsigned bankBits = 2,
    parameter int unsigned rowBits  = 13,
    parameter int unsigned colBits  = 9,
    parameter int unsigned dataBits = 16,
    localparam int unsigned addrBits = addr_bits(bankBits, rowBits, colBits),
    localparam int unsigned IdxW     = $clog2(NPORTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NPORTS-1:0]                p_r,
    input  logic [NPORTS-1:0]                p_w,
    input  logic [NPORTS-1:0][addrBits-1:0]  p_addr,
    input  logic [NPORTS-1:0][dataBits-1:0]  p_dw,
    output logic [NPORTS-1:0]                p_ack,
    output logic [dataBits-1:0]              p_dr,
    output logic [NPORTS-1:0]                p_rv,
    output logic [addrBits-1:0]              addr,
    output logic                             r,
    output logic                             w,
    output logic [dataBits-1:0]              dw,
    input  logic [dataBits-1:0]              dr,
    input  logic                             busy
);

    state_t          state_q;
    op_t             op_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] g_q;
    logic [2:0]      wait_cnt_q;

    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] pick_req;
    logic [NPORTS-1:0] pick_gnt;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_any;
    logic [NPORTS-1:0] gnt_oh;
    logic [IdxW-1:0]   gnt_idx;
    logic              gnt_any;
    logic              grant_rd;
    logic [IdxW-1:0]   next_ptr;

    assign req = p_r | p_w;

`ifdef SDRAM_ARB_PRIO0_EN
    // Port 0 is handled outside the rotation.
    assign pick_req = {req[NPORTS-1:1], 1'b0};
`else
    assign pick_req = req;
`endif

    rr_pick #(
        .N (NPORTS)
    ) u_rr_pick (
        .req (pick_req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Final grant selection: fixed-priority override for port 0 when enabled.
    always_comb begin
        gnt_oh  = pick_gnt;
        gnt_idx = pick_idx;
        gnt_any = pick_any;
`ifdef SDRAM_ARB_PRIO0_EN
        if (req[0]) begin
            gnt_oh  = NPORTS'(1);
            gnt_idx = '0;
            gnt_any = 1'b1;
        end
`endif
    end

    // A port asking for both read and write gets the read first.
    assign grant_rd = |(gnt_oh & p_r);
    assign next_ptr = (g_q == IdxW'(NPORTS - 1)) ? '0 : g_q + 1'b1;

    // Arbitration FSM with registered controller and client outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_RD;
            rr_ptr_q   <= '0;
            g_q        <= '0;
            wait_cnt_q <= '0;
            p_ack      <= '0;
            p_rv       <= '0;
            p_dr       <= '0;
            addr       <= '0;
            r          <= 1'b0;
            w          <= 1'b0;
            dw         <= '0;
        end else begin
            p_ack <= '0;
            p_rv  <= '0;
            r     <= 1'b0;
            w     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // The just-acked client still shows its request during the
                    // p_ack cycle, so no grant is made in that cycle.
                    if (!busy && gnt_any && (p_ack == '0)) begin
                        g_q     <= gnt_idx;
                        addr    <= p_addr[gnt_idx];
                        dw      <= p_dw[gnt_idx];
                        op_q    <= grant_rd ? OP_RD : OP_WR;
                        r       <= grant_rd;
                        w       <= !grant_rd;
                        state_q <= CMD;
                    end
                end
                CMD: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAITH;
                end
                WAITH: begin
                    if (busy) begin
                        state_q <= WAITL;
                    end else if (wait_cnt_q != 3'b111) begin
                        wait_cnt_q <= wait_cnt_q + 3'd1;
                    end
                end
                WAITL: begin
                    if (!busy) begin
                        p_ack[g_q] <= 1'b1;
                        if (op_q == OP_RD) begin
                            p_rv[g_q] <= 1'b1;
                            p_dr      <= dr;
                        end
                        rr_ptr_q <= next_ptr;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Protocol checks on the controller and the granted client.
    always @(posedge clk) begin
        if (!rst) begin
            if (state_q == WAITH && !busy) begin
                assert (wait_cnt_q < 3'(WaithLimit - 1))
                else $error("sdram_port_arbiter: controller never raised busy");
            end
            if (state_q != IDLE) begin
                assert ((op_q == OP_RD) ? p_r[g_q] : p_w[g_q])
                else $error("sdram_port_arbiter: client dropped request before p_ack");
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter with a behavioural controller model.
module tb_sdram_port_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    logic                 clk;
    logic                 rst;
    logic [NP-1:0]        p_r;
    logic [NP-1:0]        p_w;
    logic [NP-1:0][AW-1:0] p_addr;
    logic [NP-1:0][DW-1:0] p_dw;
    logic [NP-1:0]        p_ack;
    logic [DW-1:0]        p_dr;
    logic [NP-1:0]        p_rv;
    logic [AW-1:0]        addr;
    logic                 r;
    logic                 w;
    logic [DW-1:0]        dw;
    logic [DW-1:0]        dr;
    logic                 busy;

    sdram_port_arbiter #(
        .NPORTS   (NP),
        .bankBits (2),
        .rowBits  (13),
        .colBits  (9),
        .dataBits (DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .p_r    (p_r),
        .p_w    (p_w),
        .p_addr (p_addr),
        .p_dw   (p_dw),
        .p_ack  (p_ack),
        .p_dr   (p_dr),
        .p_rv   (p_rv),
        .addr   (addr),
        .r      (r),
        .w      (w),
        .dw     (dw),
        .dr     (dr),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: accepts a strobe while idle, busy for busy_len cycles,
    // read data valid on the first cycle busy is low again.
    int unsigned   busy_len;
    int unsigned   busy_cnt;
    logic [DW-1:0] model_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            busy_cnt <= 0;
            dr       <= '0;
        end else if (busy) begin
            if (busy_cnt <= 1) begin
                busy <= 1'b0;
                dr   <= model_rdata;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end else if (r || w) begin
            busy     <= 1'b1;
            busy_cnt <= busy_len;
        end
    end

    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    typedef struct {
        logic [NP-1:0] ack;
        logic [NP-1:0] rv;
        logic [DW-1:0] dr;
    } ack_t;

    typedef struct {
        int unsigned   port;
        bit            rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rdata;
        bit            exp_wr;
        logic [AW-1:0] exp_addr;
        logic [NP-1:0] exp_ack;
        logic [NP-1:0] exp_rv;
        logic [DW-1:0] exp_dr;
    } vec_t;

    cmd_t          cmd_q[$];
    ack_t          ack_q[$];
    logic [NP-1:0] hold;
    int            n_tests;
    int            n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: sample at the falling edge, log strobes/acks, model client drops.
    task automatic step();
        cmd_t c;
        ack_t k;
        @(negedge clk);
        if (r || w) begin
            c.wr = w;
            c.a  = addr;
            c.d  = dw;
            cmd_q.push_back(c);
        end
        if (p_ack != '0) begin
            k.ack = p_ack;
            k.rv  = p_rv;
            k.dr  = p_dr;
            ack_q.push_back(k);
            for (int i = 0; i < int'(NP); i++) begin
                if (p_ack[i] && !hold[i]) begin
                    if (p_rv[i]) p_r[i] = 1'b0;
                    else         p_w[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_acks(input string name, input int n, input int budget);
        int cnt;
        cnt = 0;
        while (ack_q.size() < n && cnt < budget) begin
            step();
            cnt++;
        end
        check({name, " ack count"}, 32'(ack_q.size()), 32'(n));
    endtask

    task automatic check_cmd(input string name, input int k, input bit exp_wr,
                             input logic [AW-1:0] exp_a, input logic [DW-1:0] exp_d,
                             input bit chk_d);
        if (k >= cmd_q.size()) begin
            check({name, " cmd present"}, 32'(cmd_q.size()), 32'(k + 1));
        end else begin
            check({name, " cmd op"}, 32'(cmd_q[k].wr), 32'(exp_wr));
            check({name, " cmd addr"}, 32'(cmd_q[k].a), 32'(exp_a));
            if (chk_d) check({name, " cmd dw"}, 32'(cmd_q[k].d), 32'(exp_d));
        end
    endtask

    task automatic check_ack(input string name, input int k, input logic [NP-1:0] exp_ack,
                             input logic [NP-1:0] exp_rv);
        if (k >= ack_q.size()) begin
            check({name, " ack present"}, 32'(ack_q.size()), 32'(k + 1));
        end else begin
            check({name, " p_ack"}, 32'(ack_q[k].ack), 32'(exp_ack));
            check({name, " p_rv"}, 32'(ack_q[k].rv), 32'(exp_rv));
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        p_r  = '0;
        p_w  = '0;
        hold = '0;
        step();
        step();
        rst = 1'b0;
        step();
        cmd_q.delete();
        ack_q.delete();
    endtask

    vec_t          vecs[6];
    logic [AW-1:0] wr_addr[4];
    logic [DW-1:0] wr_data[4];
    logic [NP-1:0] exp6[6];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        p_r         = '0;
        p_w         = '0;
        p_addr      = '0;
        p_dw        = '0;
        hold        = '0;
        busy_len    = 6;
        model_rdata = '0;

        // port, rd, addr, dw, model data | exp_wr, exp_addr, exp_ack, exp_rv, exp_dr
        vecs[0] = '{1, 1'b1, 24'h012345, 16'h0000, 16'hBEEF,
                    1'b0, 24'h012345, 4'b0010, 4'b0010, 16'hBEEF};
        vecs[1] = '{0, 1'b0, 24'h000000, 16'hFFFF, 16'h0000,
                    1'b1, 24'h000000, 4'b0001, 4'b0000, 16'h0000};
        vecs[2] = '{3, 1'b1, 24'hFFFFFF, 16'h0000, 16'h0000,
                    1'b0, 24'hFFFFFF, 4'b1000, 4'b1000, 16'h0000};
        vecs[3] = '{2, 1'b0, 24'hABCDEF, 16'h5A5A, 16'h0000,
                    1'b1, 24'hABCDEF, 4'b0100, 4'b0000, 16'h0000};
        vecs[4] = '{3, 1'b0, 24'h800001, 16'h0001, 16'h0000,
                    1'b1, 24'h800001, 4'b1000, 4'b0000, 16'h0000};
        vecs[5] = '{0, 1'b1, 24'h7FFFFE, 16'h0000, 16'hA5C3,
                    1'b0, 24'h7FFFFE, 4'b0001, 4'b0001, 16'hA5C3};

        wr_addr = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        wr_data = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
`ifdef SDRAM_ARB_PRIO0_EN
        exp6 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp6 = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
`endif

        // Reset state
        step();
        step();
        check("reset p_ack", 32'(p_ack), 32'h0);
        check("reset p_rv", 32'(p_rv), 32'h0);
        check("reset p_dr", 32'(p_dr), 32'h0);
        check("reset r/w", 32'({r, w}), 32'h0);
        check("reset addr", 32'(addr), 32'h0);
        check("reset dw", 32'(dw), 32'h0);
        rst = 1'b0;
        step();

        // Single-client transactions from the table
        for (int i = 0; i < 6; i++) begin
            cmd_q.delete();
            ack_q.delete();
            model_rdata = vecs[i].rdata;
            p_addr[vecs[i].port] = vecs[i].a;
            p_dw[vecs[i].port]   = vecs[i].d;
            if (vecs[i].rd) p_r[vecs[i].port] = 1'b1;
            else            p_w[vecs[i].port] = 1'b1;
            wait_acks($sformatf("vec%0d", i), 1, 60);
            for (int s = 0; s < 4; s++) step();
            check($sformatf("vec%0d cmd count", i), 32'(cmd_q.size()), 32'd1);
            check($sformatf("vec%0d ack total", i), 32'(ack_q.size()), 32'd1);
            check_cmd($sformatf("vec%0d", i), 0, vecs[i].exp_wr, vecs[i].exp_addr, vecs[i].d,
                      !vecs[i].rd);
            check_ack($sformatf("vec%0d", i), 0, vecs[i].exp_ack, vecs[i].exp_rv);
            if (vecs[i].rd && ack_q.size() > 0) begin
                check($sformatf("vec%0d p_dr", i), 32'(ack_q[0].dr), 32'(vecs[i].exp_dr));
            end
        end

        // All four ports write at once, twice: order 0,1,2,3 each round
        do_reset();
        for (int rnd = 0; rnd < 2; rnd++) begin
            cmd_q.delete();
            ack_q.delete();
            for (int i = 0; i < 4; i++) begin
                p_addr[i] = wr_addr[i];
                p_dw[i]   = wr_data[i];
            end
            p_w = 4'b1111;
            wait_acks($sformatf("all4 r%0d", rnd), 4, 120);
            for (int s = 0; s < 3; s++) step();
            check($sformatf("all4 r%0d cmd count", rnd), 32'(cmd_q.size()), 32'd4);
            for (int k = 0; k < 4; k++) begin
                check_cmd($sformatf("all4 r%0d #%0d", rnd, k), k, 1'b1, wr_addr[k],
                          wr_data[k], 1'b1);
                check_ack($sformatf("all4 r%0d #%0d", rnd, k), k, 4'(1 << k), 4'b0000);
            end
        end

        // Port 2 re-requests right after its ack while port 3 waits
        do_reset();
        model_rdata = 16'h0C0C;
        p_addr[2] = 24'h222000;
        p_addr[3] = 24'h333000;
        p_r[2] = 1'b1;
        for (int s = 0; s < 20 && cmd_q.size() == 0; s++) step();
        p_r[3] = 1'b1;
        wait_acks("rereq first", 1, 60);
        step();
        p_r[2] = 1'b1;
        wait_acks("rereq all", 3, 120);
        for (int s = 0; s < 3; s++) step();
        check_cmd("rereq #0", 0, 1'b0, 24'h222000, 16'h0, 1'b0);
        check_cmd("rereq #1", 1, 1'b0, 24'h333000, 16'h0, 1'b0);
        check_cmd("rereq #2", 2, 1'b0, 24'h222000, 16'h0, 1'b0);
        check_ack("rereq #1", 1, 4'b1000, 4'b1000);

        // Read and write together on port 0: read first, write on the next grant
        do_reset();
        model_rdata = 16'h1234;
        p_addr[0] = 24'h000444;
        p_dw[0]   = 16'h4444;
        p_r[0] = 1'b1;
        p_w[0] = 1'b1;
        wait_acks("rdwr", 2, 120);
        for (int s = 0; s < 3; s++) step();
        check("rdwr cmd count", 32'(cmd_q.size()), 32'd2);
        check_cmd("rdwr #0", 0, 1'b0, 24'h000444, 16'h0, 1'b0);
        check_cmd("rdwr #1", 1, 1'b1, 24'h000444, 16'h4444, 1'b1);
        check_ack("rdwr #0", 0, 4'b0001, 4'b0001);
        check_ack("rdwr #1", 1, 4'b0001, 4'b0000);
        if (ack_q.size() > 0) check("rdwr p_dr", 32'(ack_q[0].dr), 32'h1234);

        // Reset during WAITL: outputs clear at once, no ack, request re-issued once
        do_reset();
        model_rdata = 16'hCAFE;
        p_addr[1] = 24'h055555;
        p_dw[1]   = 16'h7777;
        p_r[1] = 1'b1;
        wait_acks("rst pre", 1, 60);
        step();
        cmd_q.delete();
        ack_q.delete();
        model_rdata = 16'hD00D;
        p_addr[1] = 24'h066666;
        p_r[1] = 1'b1;
        for (int s = 0; s < 20 && !busy; s++) step();
        check("rst busy seen", 32'(busy), 32'h1);
        step();
        step();
        rst = 1'b1;
        #1;
        check("rst mid p_ack", 32'(p_ack), 32'h0);
        check("rst mid p_dr", 32'(p_dr), 32'h0);
        check("rst mid addr", 32'(addr), 32'h0);
        check("rst mid dw", 32'(dw), 32'h0);
        check("rst mid r/w", 32'({r, w}), 32'h0);
        cmd_q.delete();
        ack_q.delete();
        step();
        step();
        check("rst hold no ack", 32'(ack_q.size()), 32'd0);
        rst = 1'b0;
        wait_acks("rst reissue", 1, 60);
        for (int s = 0; s < 4; s++) step();
        check("rst reissue cmd count", 32'(cmd_q.size()), 32'd1);
        check_cmd("rst reissue", 0, 1'b0, 24'h066666, 16'h0, 1'b0);
        check_ack("rst reissue", 0, 4'b0010, 4'b0010);
        if (ack_q.size() > 0) check("rst reissue p_dr", 32'(ack_q[0].dr), 32'hD00D);

        // Ports 0,1,2 request continuously
        do_reset();
        model_rdata = 16'h0606;
        p_addr[0] = 24'h600000;
        p_addr[1] = 24'h610000;
        p_addr[2] = 24'h620000;
        hold = 4'b0111;
        p_r  = 4'b0111;
        wait_acks("cont", 6, 200);
        hold = '0;
        for (int s = 0; s < 300 && (p_r != '0 || busy); s++) step();
        check("cont drained", 32'(p_r), 32'h0);
        for (int k = 0; k < 6; k++) begin
            check_ack($sformatf("cont #%0d", k), k, exp6[k], exp6[k]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
